// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
//   Initiator-side controller for a word-addressed synchronous RAM (ram_4x16
//   class). A host issues single or burst read/write commands over a
//   valid/ready handshake; write data streams in and read data streams out
//   one word per cycle. The RAM pins (rw/addr/data_in/data_out) are driven
//   only from here.
//
// Parameters
//   AW     address width; memory depth is 2^AW words, also the burst length width
//   DW     data word width
//   RD_LAT cycles from mem_addr stable to mem_rdata valid (1..4)
//
// Ports
//   clk        system clock (rising edge), also clocks the RAM
//   clr        asynchronous active-low reset
//   cmd_valid  host command valid        cmd_ready  controller idle
//   cmd_wr     1 = write, 0 = read       cmd_addr   burst start address
//   cmd_len    burst length minus one
//   wd_valid   write data valid          wd_data    write data word
//   wd_ready   write word taken this cycle
//   rd_valid   read word valid (1-cycle pulse, no backpressure)
//   rd_data    read data word            rd_last    final word of a read burst
//   busy       command in progress
//   mem_rw     RAM rw (1 = write)        mem_addr   RAM address
//   mem_wdata  RAM data_in               mem_rdata  RAM data_out
module ram_burst_ctrl #(
  parameter int AW     = 3,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wd_valid,
  input  logic [DW-1:0] wd_data,
  output logic          wd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_WFLUSH = 3'd2,
    S_READ   = 3'd3,
    S_RDRAIN = 3'd4
  } state_e;

  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

  state_e          state_q, state_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d;
  logic [AW-1:0]   beats_left_q, beats_left_d;
  logic            mem_rw_q, mem_rw_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_last_q, rd_last_d;

  // Read tags: stage 0 is loaded together with mem_addr, so a tag reaches
  // the top stage exactly when the RAM word for that address is on
  // mem_rdata and can be registered into rd_data.
  logic [RD_LAT:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT:0] tag_last_q, tag_last_d;
  logic            issue_s, issue_last_s;
  logic            tag_mature_s, tag_mature_last_s;

  assign tag_mature_s      = tag_vld_q[RD_LAT];
  assign tag_mature_last_s = tag_last_q[RD_LAT];

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign wd_ready  = (state_q == S_WRITE);
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;

  // Next-state, RAM drive and read-capture logic
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    mem_rw_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    issue_s      = 1'b0;
    issue_last_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d      = cmd_wr ? S_WRITE : S_READ;
          cur_addr_d   = cmd_addr;
          beats_left_d = cmd_len;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (wd_valid) begin
          mem_rw_d     = 1'b1;
          mem_addr_d   = cur_addr_q;
          mem_wdata_d  = wd_data;
          cur_addr_d   = cur_addr_q + ADDR_ONE;
          beats_left_d = beats_left_q - ADDR_ONE;
          if (beats_left_q == ADDR_ZERO) begin
            state_d = S_WFLUSH;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          // stall: mem_rw drops for this cycle, address holds
          mem_rw_d = 1'b0;
        end
      end
      S_WFLUSH: begin
        // the RAM commits the final word on this edge; mem_rw clears
        state_d = S_IDLE;
      end
      S_READ: begin
        issue_s      = 1'b1;
        issue_last_s = (beats_left_q == ADDR_ZERO);
        mem_addr_d   = cur_addr_q;
        cur_addr_d   = cur_addr_q + ADDR_ONE;
        beats_left_d = beats_left_q - ADDR_ONE;
        if (beats_left_q == ADDR_ZERO) begin
          state_d = S_RDRAIN;
        end else begin
          state_d = S_READ;
        end
      end
      S_RDRAIN: begin
        if (tag_mature_s && tag_mature_last_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RDRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    tag_vld_d  = {tag_vld_q[RD_LAT-1:0], issue_s};
    tag_last_d = {tag_last_q[RD_LAT-1:0], issue_last_s};

    rd_valid_d = tag_mature_s;
    rd_last_d  = tag_mature_s & tag_mature_last_s;
    if (tag_mature_s) begin
      rd_data_d = mem_rdata;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State, address/beat counters, RAM pins, read outputs and tag pipeline
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= {AW{1'b0}};
      beats_left_q <= {AW{1'b0}};
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= {AW{1'b0}};
      mem_wdata_q  <= {DW{1'b0}};
      rd_valid_q   <= 1'b0;
      rd_data_q    <= {DW{1'b0}};
      rd_last_q    <= 1'b0;
      tag_vld_q    <= {(RD_LAT+1){1'b0}};
      tag_last_q   <= {(RD_LAT+1){1'b0}};
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_last_q    <= rd_last_d;
      tag_vld_q    <= tag_vld_d;
      tag_last_q   <= tag_last_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: drives host commands, models the RAM with
// registered read latency RD_LAT, and checks RAM-side writes and host-side
// reads against scoreboard queues filled at stimulus time.
module tb_ram_burst_ctrl;
  localparam int AW     = 3;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << AW;

  logic          clk = 1'b0;
  logic          clr;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic          rd_valid, rd_last, busy;
  logic [DW-1:0] rd_data;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0]    ram     [DEPTH];
  logic [DW-1:0]    rpipe   [RD_LAT];
  logic [DW-1:0]    exp_mem [DEPTH];
  logic [AW+DW-1:0] wr_q [$];   // {addr, data} expected on the RAM pins
  logic [DW:0]      rd_q [$];   // {last, data} expected on the read port

  int n_tests = 0;
  int n_fail  = 0;

  ram_burst_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(wd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM stand-in: write on rw=1, registered read with RD_LAT stages
  always @(posedge clk) begin
    if (mem_rw) ram[mem_addr] <= mem_wdata;
    rpipe[0] <= ram[mem_addr];
    for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign mem_rdata = rpipe[RD_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0;
    repeat (3) tick();
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: cmd_ready=%b busy=%b, want 1/0", cmd_ready, busy);
    end
    n_tests++;
    if ({mem_rw, rd_valid, rd_last} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: rw/rd_valid/rd_last=%b%b%b, want 000", mem_rw, rd_valid, rd_last);
    end
    n_tests++;
    if (mem_addr !== 3'd0 || mem_wdata !== 16'h0 || rd_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_data: addr=%0d wdata=%h rdata=%h, want 0/0/0", mem_addr, mem_wdata, rd_data);
    end
    clr = 1'b1;
    tick();
    n_tests++;
    if (cmd_ready !== 1'b1 || mem_rw !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: cmd_ready=%b mem_rw=%b, want 1/0", cmd_ready, mem_rw);
    end
  endtask

  task automatic test_single();
    logic [AW+DW-1:0] wexp;
    logic [DW:0] rexp;
    int pulses, nrd, first;
    // write 16'hA5C3 to address 2
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 3'd2; cmd_len = 3'd0;
    tick(); cmd_valid = 1'b0;
    n_tests++;
    if ({busy, wd_ready, cmd_ready} !== 3'b110) begin
      n_fail++; $display("FAIL single_accept: busy/wd_ready/cmd_ready=%b%b%b, want 110", busy, wd_ready, cmd_ready);
    end
    wd_valid = 1'b1; wd_data = 16'hA5C3;
    wr_q.push_back({3'd2, 16'hA5C3}); exp_mem[2] = 16'hA5C3;
    tick(); wd_valid = 1'b0;
    wexp = wr_q.pop_front();
    n_tests++;
    if ({mem_rw, mem_addr, mem_wdata} !== {1'b1, wexp}) begin
      n_fail++; $display("FAIL single_wr: rw=%b addr=%0d data=%h, want rw=1 addr=%0d data=%h",
                         mem_rw, mem_addr, mem_wdata, wexp[DW+AW-1:DW], wexp[DW-1:0]);
    end
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (mem_rw) pulses++;
    end
    n_tests++;
    if (pulses != 0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_pulse: extra rw pulses=%0d cmd_ready=%b, want 0/1", pulses, cmd_ready);
    end
    // read it back
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 3'd2; cmd_len = 3'd0;
    rd_q.push_back({1'b1, exp_mem[2]});
    tick(); cmd_valid = 1'b0;
    nrd = 0; first = 0;
    for (int c = 1; c <= 10 && nrd < 1; c++) begin
      tick();
      if (c == 1) begin
        n_tests++;
        if (mem_addr !== 3'd2 || mem_rw !== 1'b0) begin
          n_fail++; $display("FAIL single_rd_addr: addr=%0d rw=%b, want 2/0", mem_addr, mem_rw);
        end
      end
      if (rd_valid) begin
        nrd++; first = c;
        rexp = rd_q.pop_front();
        n_tests++;
        if ({rd_last, rd_data} !== rexp) begin
          n_fail++; $display("FAIL single_rd: last=%b data=%h, want last=%b data=%h", rd_last, rd_data, rexp[DW], rexp[DW-1:0]);
        end
      end
    end
    n_tests++;
    if (first != 2 + RD_LAT || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_rd_latency: rd_valid cycle=%0d cmd_ready=%b, want %0d/1", first, cmd_ready, 2 + RD_LAT);
    end
    tick();
    n_tests++;
    if ({rd_valid, rd_last} !== 2'b00) begin
      n_fail++; $display("FAIL single_rd_pulse: rd_valid/rd_last=%b%b, want 00", rd_valid, rd_last);
    end
  endtask

  task automatic test_wrap_burst();
    logic [AW+DW-1:0] wexp;
    logic [DW:0] rexp;
    logic [AW-1:0] a;
    int nrd, first, lastc;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 3'd5; cmd_len = 3'd7;
    tick(); cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = 3'd5 + i[2:0];
      wd_valid = 1'b1; wd_data = 16'h0100 + i[15:0];
      wr_q.push_back({a, wd_data}); exp_mem[a] = wd_data;
      tick();
      wexp = wr_q.pop_front();
      n_tests++;
      if ({mem_rw, mem_addr, mem_wdata} !== {1'b1, wexp}) begin
        n_fail++; $display("FAIL wrap_wr beat %0d: rw=%b addr=%0d data=%h, want rw=1 addr=%0d data=%h",
                           i, mem_rw, mem_addr, mem_wdata, wexp[DW+AW-1:DW], wexp[DW-1:0]);
      end
    end
    wd_valid = 1'b0;
    n_tests++;
    if (cmd_ready !== 1'b0 || wd_ready !== 1'b0) begin
      n_fail++; $display("FAIL wrap_flush: cmd_ready=%b wd_ready=%b, want 0/0", cmd_ready, wd_ready);
    end
    tick();
    n_tests++;
    if (mem_rw !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL wrap_done: mem_rw=%b cmd_ready=%b, want 0/1", mem_rw, cmd_ready);
    end
    // read the whole memory back starting at 5
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 3'd5; cmd_len = 3'd7;
    for (int i = 0; i < 8; i++) begin
      a = 3'd5 + i[2:0];
      rd_q.push_back({(i == 7), exp_mem[a]});
    end
    tick(); cmd_valid = 1'b0;
    nrd = 0; first = 0; lastc = 0;
    for (int c = 1; c <= 30 && nrd < 8; c++) begin
      tick();
      if (rd_valid) begin
        nrd++; lastc = c;
        if (first == 0) first = c;
        if (rd_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL wrap_rd_extra: unexpected word %h", rd_data);
        end else begin
          rexp = rd_q.pop_front();
          n_tests++;
          if ({rd_last, rd_data} !== rexp) begin
            n_fail++; $display("FAIL wrap_rd word %0d: last=%b data=%h, want last=%b data=%h",
                               nrd - 1, rd_last, rd_data, rexp[DW], rexp[DW-1:0]);
          end
        end
      end
    end
    n_tests++;
    if (nrd != 8 || first != 2 + RD_LAT || lastc - first != 7) begin
      n_fail++; $display("FAIL wrap_rd_stream: words=%0d first=%0d span=%0d, want 8/%0d/7", nrd, first, lastc - first, 2 + RD_LAT);
    end
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL wrap_rd_idle: cmd_ready=%b, want 1", cmd_ready);
    end
    rd_q.delete();
  endtask

  task automatic test_write_stall();
    logic [AW+DW-1:0] wexp;
    logic [4:0] pat;
    logic [AW-1:0] a;
    int k;
    pat = 5'b11001;  // wd_valid per cycle, LSB first: 1,0,0,1,1
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 3'd3; cmd_len = 3'd2;
    tick(); cmd_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      wd_valid = pat[i]; wd_data = 16'h5A00 + i[15:0];
      if (pat[i]) begin
        a = 3'd3 + k[2:0];
        wr_q.push_back({a, wd_data}); exp_mem[a] = wd_data; k++;
      end
      tick();
      n_tests++;
      if (mem_rw !== pat[i]) begin
        n_fail++; $display("FAIL stall_rw cycle %0d: mem_rw=%b, want %b", i, mem_rw, pat[i]);
      end
      if (pat[i]) begin
        wexp = wr_q.pop_front();
        n_tests++;
        if ({mem_addr, mem_wdata} !== wexp) begin
          n_fail++; $display("FAIL stall_wr cycle %0d: addr=%0d data=%h, want addr=%0d data=%h",
                             i, mem_addr, mem_wdata, wexp[DW+AW-1:DW], wexp[DW-1:0]);
        end
      end
    end
    // extra write data after the burst must not be consumed
    wd_valid = 1'b1; wd_data = 16'hDEAD;
    n_tests++;
    if (cmd_ready !== 1'b0 || wd_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_flush: cmd_ready=%b wd_ready=%b, want 0/0", cmd_ready, wd_ready);
    end
    tick();
    n_tests++;
    if (mem_rw !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_done: mem_rw=%b cmd_ready=%b, want 0/1", mem_rw, cmd_ready);
    end
    tick(); tick();
    n_tests++;
    if (mem_rw !== 1'b0 || wd_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_extra_wd: mem_rw=%b wd_ready=%b busy=%b, want 0/0/0", mem_rw, wd_ready, busy);
    end
    wd_valid = 1'b0;
  endtask

  task automatic test_busy_reject();
    logic [AW+DW-1:0] wexp;
    logic [DW:0] rexp;
    logic [AW-1:0] a;
    int nrd;
    bit seen_ready;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 3'd3; cmd_len = 3'd2;
    for (int i = 0; i < 3; i++) begin
      a = 3'd3 + i[2:0];
      rd_q.push_back({(i == 2), exp_mem[a]});
    end
    tick();
    // a second command held while the read is in flight
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 3'd7; cmd_len = 3'd0;
    nrd = 0; seen_ready = 1'b0;
    for (int c = 1; c <= 20 && !seen_ready; c++) begin
      tick();
      if (rd_valid) begin
        nrd++;
        if (rd_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL busy_rd_extra: unexpected word %h", rd_data);
        end else begin
          rexp = rd_q.pop_front();
          n_tests++;
          if ({rd_last, rd_data} !== rexp) begin
            n_fail++; $display("FAIL busy_rd word %0d: last=%b data=%h, want last=%b data=%h",
                               nrd - 1, rd_last, rd_data, rexp[DW], rexp[DW-1:0]);
          end
        end
      end
      if (cmd_ready) seen_ready = 1'b1;
    end
    n_tests++;
    if (!seen_ready || nrd != 3) begin
      n_fail++; $display("FAIL busy_reject: ready_seen=%0d words_before_ready=%0d, want 1/3", seen_ready, nrd);
    end
    rd_q.delete();
    // still held: taken on the next edge
    wr_q.push_back({3'd7, 16'hC0DE}); exp_mem[7] = 16'hC0DE;
    tick(); cmd_valid = 1'b0;
    n_tests++;
    if ({busy, wd_ready} !== 2'b11) begin
      n_fail++; $display("FAIL busy_accept: busy/wd_ready=%b%b, want 11", busy, wd_ready);
    end
    wd_valid = 1'b1; wd_data = 16'hC0DE;
    tick(); wd_valid = 1'b0;
    wexp = wr_q.pop_front();
    n_tests++;
    if ({mem_rw, mem_addr, mem_wdata} !== {1'b1, wexp}) begin
      n_fail++; $display("FAIL busy_wr: rw=%b addr=%0d data=%h, want rw=1 addr=%0d data=%h",
                         mem_rw, mem_addr, mem_wdata, wexp[DW+AW-1:DW], wexp[DW-1:0]);
    end
    tick();
    n_tests++;
    if (cmd_ready !== 1'b1 || mem_rw !== 1'b0) begin
      n_fail++; $display("FAIL busy_done: cmd_ready=%b mem_rw=%b, want 1/0", cmd_ready, mem_rw);
    end
  endtask

  task automatic test_abort();
    logic [DW:0] rexp;
    int nrd;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 3'd0; cmd_len = 3'd5;
    tick(); cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wd_valid = 1'b1; wd_data = 16'hB000 + i[15:0];
      tick();
      n_tests++;
      if (mem_rw !== 1'b1 || mem_addr !== i[2:0]) begin
        n_fail++; $display("FAIL abort_beat %0d: rw=%b addr=%0d, want 1/%0d", i, mem_rw, mem_addr, i);
      end
    end
    // beats 0 and 1 are committed; beat 2 is still on the pins
    exp_mem[0] = 16'hB000; exp_mem[1] = 16'hB001;
    wd_valid = 1'b0;
    clr = 1'b0;
    #1;
    n_tests++;
    if (mem_rw !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_immediate: mem_rw=%b cmd_ready=%b, want 0/1", mem_rw, cmd_ready);
    end
    tick();
    clr = 1'b1;
    tick();
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || mem_rw !== 1'b0) begin
      n_fail++; $display("FAIL abort_release: cmd_ready=%b busy=%b mem_rw=%b, want 1/0/0", cmd_ready, busy, mem_rw);
    end
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 3'd0; cmd_len = 3'd2;
    for (int i = 0; i < 3; i++) rd_q.push_back({(i == 2), exp_mem[i]});
    tick(); cmd_valid = 1'b0;
    nrd = 0;
    for (int c = 1; c <= 20 && nrd < 3; c++) begin
      tick();
      if (rd_valid) begin
        nrd++;
        if (rd_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL abort_rd_extra: unexpected word %h", rd_data);
        end else begin
          rexp = rd_q.pop_front();
          n_tests++;
          if ({rd_last, rd_data} !== rexp) begin
            n_fail++; $display("FAIL abort_rd word %0d: last=%b data=%h, want last=%b data=%h",
                               nrd - 1, rd_last, rd_data, rexp[DW], rexp[DW-1:0]);
          end
        end
      end
    end
    n_tests++;
    if (nrd != 3 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_rd_count: words=%0d cmd_ready=%b, want 3/1", nrd, cmd_ready);
    end
    rd_q.delete();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 16'h0;
      exp_mem[i] = 16'h0;
    end
    for (int k = 0; k < RD_LAT; k++) rpipe[k] = 16'h0;
    test_reset();
    test_single();
    test_wrap_burst();
    test_write_stall();
    test_busy_reject();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
